// File: rtl/mult_pipe_fu_pkg.sv
// Shared types for the pipelined multiply functional unit: function codes,
// default depth, and the response bundle seen by the complete stage.
`ifndef MULT_PIPE_FU_STAGES
`define MULT_PIPE_FU_STAGES 4
`endif

package mult_pipe_fu_pkg;

    localparam int MULT_STAGES_DEFAULT = `MULT_PIPE_FU_STAGES;

    // Encodings follow RV32M funct3 so the issue queue can pass funct3 straight through.
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mult_func_e;

    localparam int FU_XLEN  = 32;
    localparam int FU_TAG_W = 7;
    localparam int FU_ROB_W = 6;

    typedef struct packed {
        logic                valid;
        logic [FU_XLEN-1:0]  value;
        logic [FU_TAG_W-1:0] dest_prf;
        logic [FU_ROB_W-1:0] rob_idx;
    } fu_resp_t;

endpackage

// File: rtl/mult_stage.sv
// One multiplier slot: folds CHUNK multiplier bits into the partial product on load.
// Latency 1 cycle; holds contents while not advancing, valid clears on flush.
module mult_stage
    import mult_pipe_fu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8,
    parameter int TW    = 7,
    parameter int RW    = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  mult_func_e        func_i,
    input  logic [TW-1:0]     dest_i,
    input  logic [RW-1:0]     rob_i,
    input  logic [2*XLEN-1:0] pp_i,
    input  logic [2*XLEN-1:0] mcand_i,
    input  logic [XLEN-1:0]   mplier_i,
    output logic              valid_o,
    output logic              valid_d_o,
    output mult_func_e        func_o,
    output logic [TW-1:0]     dest_o,
    output logic [RW-1:0]     rob_o,
    output logic [2*XLEN-1:0] pp_o,
    output logic [2*XLEN-1:0] mcand_o,
    output logic [XLEN-1:0]   mplier_o
);
    localparam int PW = 2 * XLEN;

    logic            valid_q,  valid_d;
    mult_func_e      func_q,   func_d;
    logic [TW-1:0]   dest_q,   dest_d;
    logic [RW-1:0]   rob_q,    rob_d;
    logic [PW-1:0]   pp_q,     pp_d;
    logic [PW-1:0]   mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;

    always_comb begin
        valid_d  = valid_q;
        func_d   = func_q;
        dest_d   = dest_q;
        rob_d    = rob_q;
        pp_d     = pp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (flush_i)     valid_d = 1'b0;
        else if (load_i) valid_d = 1'b1;
        else if (adv_i)  valid_d = 1'b0;
        if (load_i) begin
            func_d   = func_i;
            dest_d   = dest_i;
            rob_d    = rob_i;
            pp_d     = pp_i + mcand_i * PW'(mplier_i[CHUNK-1:0]);
            mcand_d  = mcand_i << CHUNK;
            mplier_d = mplier_i >> CHUNK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            func_q   <= MUL;
            dest_q   <= '0;
            rob_q    <= '0;
            pp_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            valid_q  <= valid_d;
            func_q   <= func_d;
            dest_q   <= dest_d;
            rob_q    <= rob_d;
            pp_q     <= pp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign valid_o   = valid_q;
    assign valid_d_o = valid_d;
    assign func_o    = func_q;
    assign dest_o    = dest_q;
    assign rob_o     = rob_q;
    assign pp_o      = pp_q;
    assign mcand_o   = mcand_q;
    assign mplier_o  = mplier_q;

endmodule

// File: rtl/mult_pipe_fu.sv
// Elastic STAGES-deep shift-add multiplier FU (MUL/MULH/MULHSU/MULHU) with tag pass-through.
// Latency STAGES cycles unstalled, 1/cycle; bubbles collapse, full pipe drops req_ready_o.
module mult_pipe_fu
    import mult_pipe_fu_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int STAGES    = MULT_STAGES_DEFAULT,
    parameter  int PHYS_REGS = 128,
    parameter  int ROB_DEPTH = 64,
    localparam int TW        = $clog2(PHYS_REGS),
    localparam int RW        = $clog2(ROB_DEPTH),
    localparam int OW        = $clog2(STAGES + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_func_i,
    input  logic [XLEN-1:0] req_src1_i,
    input  logic [XLEN-1:0] req_src2_i,
    input  logic [TW-1:0]   req_dest_prf_i,
    input  logic [RW-1:0]   req_rob_idx_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_value_o,
    output logic [TW-1:0]   resp_dest_prf_o,
    output logic [RW-1:0]   resp_rob_idx_o,
    output logic [OW-1:0]   occupancy_o
);
    localparam int CHUNK = XLEN / STAGES;
    localparam int PW    = 2 * XLEN;
    localparam int L     = STAGES - 1;

    if (STAGES < 1 || STAGES > XLEN || (XLEN % STAGES) != 0) begin : g_bad_cfg
        $error("mult_pipe_fu: STAGES must divide XLEN and lie in 1..XLEN");
    end

    logic [STAGES-1:0] valid, valid_d, adv, load;
    mult_func_e        func_s   [STAGES];
    logic [TW-1:0]     dest_s   [STAGES];
    logic [RW-1:0]     rob_s    [STAGES];
    logic [PW-1:0]     pp_s     [STAGES];
    logic [PW-1:0]     mcand_s  [STAGES];
    logic [XLEN-1:0]   mplier_s [STAGES];

    mult_func_e    in_func;
    logic [PW-1:0] in_pp, in_mcand;
    logic [OW-1:0] occupancy_q, occupancy_d;
    logic          unused_tail;

    // A slot moves when the slot after it is empty or itself moving.
    always_comb begin
        adv    = '0;
        adv[L] = valid[L] && resp_ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = valid[k] && (!valid[k+1] || adv[k+1]);
        end
    end

    assign req_ready_o = !valid[0] || adv[0];

    always_comb begin
        load    = '0;
        load[0] = req_valid_i && req_ready_o && !flush_i;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    // Only the low XLEN multiplier bits are stepped; a negative signed rs2
    // contributes -(rs1 << XLEN) modulo 2^(2*XLEN), which seeds the product.
    always_comb begin
        in_func  = mult_func_e'(req_func_i);
        in_mcand = (in_func != MULHU) ? {{XLEN{req_src1_i[XLEN-1]}}, req_src1_i}
                                      : {{XLEN{1'b0}}, req_src1_i};
        in_pp    = '0;
        if ((in_func == MUL || in_func == MULH) && req_src2_i[XLEN-1]) begin
            in_pp = PW'(0) - {req_src1_i, {XLEN{1'b0}}};
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        mult_func_e      func_in;
        logic [TW-1:0]   dest_in;
        logic [RW-1:0]   rob_in;
        logic [PW-1:0]   pp_in, mcand_in;
        logic [XLEN-1:0] mplier_in;

        if (k == 0) begin : g_head
            assign func_in   = in_func;
            assign dest_in   = req_dest_prf_i;
            assign rob_in    = req_rob_idx_i;
            assign pp_in     = in_pp;
            assign mcand_in  = in_mcand;
            assign mplier_in = req_src2_i;
        end else begin : g_body
            assign func_in   = func_s[k-1];
            assign dest_in   = dest_s[k-1];
            assign rob_in    = rob_s[k-1];
            assign pp_in     = pp_s[k-1];
            assign mcand_in  = mcand_s[k-1];
            assign mplier_in = mplier_s[k-1];
        end

        mult_stage #(
            .XLEN (XLEN),
            .CHUNK(CHUNK),
            .TW   (TW),
            .RW   (RW)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .flush_i  (flush_i),
            .load_i   (load[k]),
            .adv_i    (adv[k]),
            .func_i   (func_in),
            .dest_i   (dest_in),
            .rob_i    (rob_in),
            .pp_i     (pp_in),
            .mcand_i  (mcand_in),
            .mplier_i (mplier_in),
            .valid_o  (valid[k]),
            .valid_d_o(valid_d[k]),
            .func_o   (func_s[k]),
            .dest_o   (dest_s[k]),
            .rob_o    (rob_s[k]),
            .pp_o     (pp_s[k]),
            .mcand_o  (mcand_s[k]),
            .mplier_o (mplier_s[k])
        );
    end

    assign unused_tail = ^{mcand_s[L], mplier_s[L]};

    assign resp_valid_o = valid[L];

    always_comb begin
        resp_value_o    = '0;
        resp_dest_prf_o = '0;
        resp_rob_idx_o  = '0;
        if (valid[L]) begin
            resp_value_o    = (func_s[L] == MUL) ? pp_s[L][XLEN-1:0] : pp_s[L][PW-1:XLEN];
            resp_dest_prf_o = dest_s[L];
            resp_rob_idx_o  = rob_s[L];
        end
    end

    always_comb begin
        occupancy_d = OW'($countones(valid_d));
    end

    always_ff @(posedge clock) begin
        if (reset) occupancy_q <= '0;
        else       occupancy_q <= occupancy_d;
    end

    assign occupancy_o = occupancy_q;

endmodule

// File: tb/tb_mult_pipe_fu.sv
// Directed bench for mult_pipe_fu: latency, signedness, backpressure, bubbles,
// flush, reset, plus STAGES=1/2/8 instances against a reference multiply.
module tb_mult_pipe_fu;
    import mult_pipe_fu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_func = 3'd0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [6:0]  dest = '0;
    logic [5:0]  rob = '0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;

    logic        rdy, vld;
    logic [31:0] val;
    logic [6:0]  dst;
    logic [5:0]  rb;
    logic [2:0]  occ;

    logic        rdy1, vld1, rdy2, vld2, rdy8, vld8;
    logic [31:0] val1, val2, val8;
    logic [6:0]  dst1, dst2, dst8;
    logic [5:0]  rb1, rb2, rb8;
    logic [0:0]  occ1;
    logic [1:0]  occ2;
    logic [3:0]  occ8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mult_pipe_fu u_dut (
        .clock(clock), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy),
        .req_func_i(req_func), .req_src1_i(src1), .req_src2_i(src2),
        .req_dest_prf_i(dest), .req_rob_idx_i(rob), .flush_i(flush),
        .resp_valid_o(vld), .resp_ready_i(resp_ready), .resp_value_o(val),
        .resp_dest_prf_o(dst), .resp_rob_idx_o(rb), .occupancy_o(occ)
    );

    mult_pipe_fu #(.STAGES(1)) u_s1 (
        .clock(clock), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req_func_i(req_func), .req_src1_i(src1), .req_src2_i(src2),
        .req_dest_prf_i(dest), .req_rob_idx_i(rob), .flush_i(flush),
        .resp_valid_o(vld1), .resp_ready_i(resp_ready), .resp_value_o(val1),
        .resp_dest_prf_o(dst1), .resp_rob_idx_o(rb1), .occupancy_o(occ1)
    );

    mult_pipe_fu #(.STAGES(2)) u_s2 (
        .clock(clock), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy2),
        .req_func_i(req_func), .req_src1_i(src1), .req_src2_i(src2),
        .req_dest_prf_i(dest), .req_rob_idx_i(rob), .flush_i(flush),
        .resp_valid_o(vld2), .resp_ready_i(resp_ready), .resp_value_o(val2),
        .resp_dest_prf_o(dst2), .resp_rob_idx_o(rb2), .occupancy_o(occ2)
    );

    mult_pipe_fu #(.STAGES(8)) u_s8 (
        .clock(clock), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy8),
        .req_func_i(req_func), .req_src1_i(src1), .req_src2_i(src2),
        .req_dest_prf_i(dest), .req_rob_idx_i(rob), .flush_i(flush),
        .resp_valid_o(vld8), .resp_ready_i(resp_ready), .resp_value_o(val8),
        .resp_dest_prf_o(dst8), .resp_rob_idx_o(rb8), .occupancy_o(occ8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] d, input logic [5:0] r);
        req_valid = 1'b1;
        req_func  = f;
        src1      = a;
        src2      = b;
        dest      = d;
        rob       = r;
    endtask

    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f == 3'd3) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (f == 3'd0 || f == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    localparam int NV = 6;
    logic [2:0]  v_func [NV] = '{MULH, MULHU, MULHSU, MUL, MULH, MULHSU};
    logic [31:0] v_a    [NV] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] v_b    [NV] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002,
                                 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] v_exp  [NV] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF1, 32'h0000_0000, 32'h8000_0000};

    initial begin
        int stray;
        int lat1, lat2, lat8;
        logic [31:0] got1, got2, got8, a, b, e;
        logic [2:0] f;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_vld", 64'(vld), 64'd0);
        check("rst_val", 64'(val), 64'd0);
        check("rst_dst", 64'(dst), 64'd0);
        check("rst_rob", 64'(rb), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_rdy", 64'(rdy), 64'd1);

        // Single MUL: 7*6 with latency 4
        drive(MUL, 32'd7, 32'd6, 7'd5, 6'd3);
        check("mul_rdy", 64'(rdy), 64'd1);
        tick();
        req_valid = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            check($sformatf("mul_lat_t%0d", t), 64'(vld), 64'(t == 4));
            if (t < 4) tick();
        end
        check("mul_val", 64'(val), 64'd42);
        check("mul_dst", 64'(dst), 64'd5);
        check("mul_rob", 64'(rb), 64'd3);
        check("mul_occ", 64'(occ), 64'd1);
        tick();
        check("mul_done_vld", 64'(vld), 64'd0);
        check("mul_done_val", 64'(val), 64'd0);
        tick(); tick();

        // Back-to-back signedness vectors at full throughput
        for (int c = 0; c < NV + 6; c++) begin
            int  idx;
            logic ev;
            idx = c - 4;
            ev  = (idx >= 0 && idx < NV);
            check($sformatf("strm_vld_c%0d", c), 64'(vld), 64'(ev));
            if (ev) begin
                check($sformatf("strm_val_%0d", idx), 64'(val), 64'(v_exp[idx]));
                check($sformatf("strm_dst_%0d", idx), 64'(dst), 64'(10 + idx));
            end
            if (c < NV) drive(v_func[c], v_a[c], v_b[c], 7'(10 + c), 6'(20 + c));
            else        req_valid = 1'b0;
            tick();
        end

        // Backpressure: fill all four slots, then drain in order
        resp_ready = 1'b0;
        drive(MUL, 32'd2, 32'd3, 7'd40, 6'd1);     tick();
        drive(MUL, 32'd4, 32'd5, 7'd41, 6'd2);     tick();
        drive(MUL, 32'd10, 32'd10, 7'd42, 6'd3);   tick();
        drive(MULHU, 32'hFFFF_FFFF, 32'h10, 7'd43, 6'd4); tick();
        drive(MUL, 32'd9, 32'd9, 7'd44, 6'd5);
        check("full_occ", 64'(occ), 64'd4);
        check("full_rdy", 64'(rdy), 64'd0);
        check("full_val", 64'(val), 64'd6);
        tick(); tick();
        check("hold_vld", 64'(vld), 64'd1);
        check("hold_val", 64'(val), 64'd6);
        check("hold_dst", 64'(dst), 64'd40);
        check("hold_occ", 64'(occ), 64'd4);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        check("drain_a", 64'(val), 64'd6);     tick();
        check("drain_b", 64'(val), 64'd20);
        check("drain_b_vld", 64'(vld), 64'd1); tick();
        check("drain_c", 64'(val), 64'd100);   tick();
        check("drain_d", 64'(val), 64'hF);
        check("drain_d_dst", 64'(dst), 64'd43); tick();
        check("drain_end_vld", 64'(vld), 64'd0);
        stray = 0;
        for (int t = 0; t < 6; t++) begin
            if (vld) stray++;
            tick();
        end
        check("drain_no_extra", 64'(stray), 64'd0);

        // Bubble collapse behind a stalled result
        resp_ready = 1'b0;
        drive(MUL, 32'd3, 32'd3, 7'd50, 6'd6); tick();
        req_valid = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        drive(MUL, 32'd4, 32'd4, 7'd51, 6'd7); tick();
        req_valid = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        check("bub_occ", 64'(occ), 64'd2);
        check("bub_rdy", 64'(rdy), 64'd1);
        check("bub_val_a", 64'(val), 64'd9);
        resp_ready = 1'b1;
        tick();
        check("bub_vld_b", 64'(vld), 64'd1);
        check("bub_val_b", 64'(val), 64'd16);
        tick();
        check("bub_end", 64'(vld), 64'd0);

        // Flush with two in flight and a same-cycle request
        drive(MUL, 32'd11, 32'd11, 7'd60, 6'd8); tick();
        drive(MUL, 32'd12, 32'd12, 7'd61, 6'd9); tick();
        drive(MUL, 32'd13, 32'd13, 7'd62, 6'd10);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_occ", 64'(occ), 64'd0);
        check("flush_vld", 64'(vld), 64'd0);
        stray = 0;
        for (int t = 0; t < 10; t++) begin
            if (vld) stray++;
            tick();
        end
        check("flush_no_resp", 64'(stray), 64'd0);

        // Reset with three in flight and a pending request
        drive(MUL, 32'd2, 32'd2, 7'd70, 6'd11); tick();
        drive(MUL, 32'd3, 32'd2, 7'd71, 6'd12); tick();
        drive(MUL, 32'd4, 32'd2, 7'd72, 6'd13); tick();
        drive(MUL, 32'd5, 32'd2, 7'd73, 6'd14);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 1'b0;
        check("rst_mid_vld", 64'(vld), 64'd0);
        check("rst_mid_occ", 64'(occ), 64'd0);
        check("rst_mid_rdy", 64'(rdy), 64'd1);
        stray = 0;
        for (int t = 0; t < 8; t++) begin
            if (vld) stray++;
            tick();
        end
        check("rst_mid_no_resp", 64'(stray), 64'd0);

        // Depth sweep: STAGES=1,2,8 against the reference multiply
        for (int i = 0; i < 6; i++) begin
            f = 3'(i % 4);
            a = (i == 0) ? 32'h8000_0000 : $urandom;
            b = (i == 1) ? 32'hFFFF_FFFF : $urandom;
            e = ref_mul(f, a, b);
            drive(f, a, b, 7'(i), 6'(i));
            tick();
            req_valid = 1'b0;
            lat1 = 0; lat2 = 0; lat8 = 0;
            got1 = '0; got2 = '0; got8 = '0;
            for (int t = 1; t <= 10; t++) begin
                if (vld1 && lat1 == 0) begin lat1 = t; got1 = val1; end
                if (vld2 && lat2 == 0) begin lat2 = t; got2 = val2; end
                if (vld8 && lat8 == 0) begin lat8 = t; got8 = val8; end
                tick();
            end
            check($sformatf("sw1_lat_%0d", i), 64'(lat1), 64'd1);
            check($sformatf("sw1_val_%0d", i), 64'(got1), 64'(e));
            check($sformatf("sw2_lat_%0d", i), 64'(lat2), 64'd2);
            check($sformatf("sw2_val_%0d", i), 64'(got2), 64'(e));
            check($sformatf("sw8_lat_%0d", i), 64'(lat8), 64'd8);
            check($sformatf("sw8_val_%0d", i), 64'(got8), 64'(e));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
